// File: rtl/aclk_pkg.sv
// Shared alarm-clock constants: BCD digit width, digit maxima, time bundle.
// Used by the counter, LCD driver and alarm register stages.
package aclk_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam bcd_t MS_HR_MAX       = 4'd2;
  localparam bcd_t LS_HR_MAX       = 4'd9;
  localparam bcd_t LS_HR_MAX_AT_20 = 4'd3;
  localparam bcd_t MS_MIN_MAX      = 4'd5;
  localparam bcd_t LS_MIN_MAX      = 4'd9;

  typedef struct packed {
    bcd_t ms_hr;
    bcd_t ls_hr;
    bcd_t ms_min;
    bcd_t ls_min;
  } hhmm_t;

  function automatic logic time_valid(hhmm_t t);
    logic hr_ok;
    hr_ok = (t.ms_hr < MS_HR_MAX && t.ls_hr <= LS_HR_MAX) ||
            (t.ms_hr == MS_HR_MAX && t.ls_hr <= LS_HR_MAX_AT_20);
    return hr_ok && t.ms_min <= MS_MIN_MAX && t.ls_min <= LS_MIN_MAX;
  endfunction

endpackage

// File: rtl/aclk_counter_if.sv
// Time-of-day counter bus: timebase/FSM strobes, load value, current time.
// master = upstream driver of strobes, slave = the counter.
interface aclk_counter_if;
  import aclk_pkg::*;

  logic one_minute;
  logic load_new_c;
  bcd_t new_current_time_ms_hr;
  bcd_t new_current_time_ls_hr;
  bcd_t new_current_time_ms_min;
  bcd_t new_current_time_ls_min;
  bcd_t current_time_ms_hr;
  bcd_t current_time_ls_hr;
  bcd_t current_time_ms_min;
  bcd_t current_time_ls_min;
  logic load_err;
  logic day_wrap;

  modport master (
    output one_minute, load_new_c,
    output new_current_time_ms_hr, new_current_time_ls_hr,
    output new_current_time_ms_min, new_current_time_ls_min,
    input  current_time_ms_hr, current_time_ls_hr,
    input  current_time_ms_min, current_time_ls_min,
    input  load_err, day_wrap
  );

  modport slave (
    input  one_minute, load_new_c,
    input  new_current_time_ms_hr, new_current_time_ls_hr,
    input  new_current_time_ms_min, new_current_time_ls_min,
    output current_time_ms_hr, current_time_ls_hr,
    output current_time_ms_min, current_time_ls_min,
    output load_err, day_wrap
  );

endinterface

// File: rtl/aclk_bcd_digit.sv
// One BCD digit: modulo-(MAX+1) counter with load.
// carry_out flags the digit sitting at MAX, so the next inc wraps it.
module aclk_bcd_digit
  import aclk_pkg::*;
#(
  parameter bcd_t MAX = 4'd9,
  parameter bcd_t RST = 4'd0
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic load,
  input  bcd_t load_val,
  output bcd_t q,
  output logic carry_out
);

  assign carry_out = (q == MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      q <= RST;
    else if (load)
      q <= load_val;
    else if (inc)
      q <= carry_out ? '0 : q + 4'd1;
  end

endmodule

// File: rtl/aclk_counter.sv
// Alarm-clock time-of-day counter, HH:MM in BCD, 24 h.
// Minute ticks ripple through four digit counters within one edge.
module aclk_counter
  import aclk_pkg::*;
#(
  parameter bcd_t RST_MS_HR  = 4'd0,
  parameter bcd_t RST_LS_HR  = 4'd0,
  parameter bcd_t RST_MS_MIN = 4'd0,
  parameter bcd_t RST_LS_MIN = 4'd0
) (
  input  logic clock,
  input  logic reset,
  aclk_counter_if.slave bus
);

  hhmm_t nv;
  hhmm_t cur;
  logic  ld_ok;
  logic  tick;
  logic  lm_max, mm_max, lh_max, mh_max;
  logic  c_mm, c_hr, hr_wrap;
  logic  hr_ld;
  bcd_t  ms_hr_val, ls_hr_val;

  assign nv = {bus.new_current_time_ms_hr, bus.new_current_time_ls_hr,
               bus.new_current_time_ms_min, bus.new_current_time_ls_min};

  // A load (valid or not) swallows a coincident tick.
  assign ld_ok = bus.load_new_c && time_valid(nv);
  assign tick  = bus.one_minute && !bus.load_new_c;

  assign c_mm    = tick && lm_max;
  assign c_hr    = c_mm && mm_max;
  assign hr_wrap = c_hr && mh_max && (cur.ls_hr == LS_HR_MAX_AT_20);

  // 23 -> 00 is forced by loading zero into both hour digits.
  assign hr_ld     = ld_ok || hr_wrap;
  assign ms_hr_val = hr_wrap ? '0 : nv.ms_hr;
  assign ls_hr_val = hr_wrap ? '0 : nv.ls_hr;

  aclk_bcd_digit #(.MAX(LS_MIN_MAX), .RST(RST_LS_MIN)) u_ls_min (
    .clock(clock), .reset(reset),
    .inc(tick), .load(ld_ok), .load_val(nv.ls_min),
    .q(cur.ls_min), .carry_out(lm_max)
  );

  aclk_bcd_digit #(.MAX(MS_MIN_MAX), .RST(RST_MS_MIN)) u_ms_min (
    .clock(clock), .reset(reset),
    .inc(c_mm), .load(ld_ok), .load_val(nv.ms_min),
    .q(cur.ms_min), .carry_out(mm_max)
  );

  aclk_bcd_digit #(.MAX(LS_HR_MAX), .RST(RST_LS_HR)) u_ls_hr (
    .clock(clock), .reset(reset),
    .inc(c_hr), .load(hr_ld), .load_val(ls_hr_val),
    .q(cur.ls_hr), .carry_out(lh_max)
  );

  aclk_bcd_digit #(.MAX(MS_HR_MAX), .RST(RST_MS_HR)) u_ms_hr (
    .clock(clock), .reset(reset),
    .inc(c_hr && lh_max), .load(hr_ld), .load_val(ms_hr_val),
    .q(cur.ms_hr), .carry_out(mh_max)
  );

  assign bus.current_time_ms_hr  = cur.ms_hr;
  assign bus.current_time_ls_hr  = cur.ls_hr;
  assign bus.current_time_ms_min = cur.ms_min;
  assign bus.current_time_ls_min = cur.ls_min;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.load_err <= 1'b0;
      bus.day_wrap <= 1'b0;
    end else begin
      bus.load_err <= bus.load_new_c && !ld_ok;
      bus.day_wrap <= hr_wrap;
    end
  end

endmodule
